// File: rtl/conv1_pkg.sv
// Shared constants, widths and types for the conv1 front-end.
//   IMG_W / IMG_H       default image geometry
//   KERNEL_SIZE         window edge length
//   WINDOW_SIZE         pixels per window
//   ROW_W/COL_W/WIN_W   counter widths at the default geometry
//   state_t             sequencer state encoding (IDLE, RUN, DONE)
//   window_t            3x3 window payload, one packed row per field
package conv1_pkg;

  localparam int unsigned IMG_W       = 28;
  localparam int unsigned IMG_H       = 28;
  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned WINDOW_SIZE = KERNEL_SIZE * KERNEL_SIZE;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ROW_W = bits_for(IMG_H);
  localparam int unsigned COL_W = bits_for(IMG_W);
  localparam int unsigned WIN_W = bits_for((IMG_W - 2) * (IMG_H - 2));

  // Sequencer state encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Bit [0] of each row is the newest column.
  typedef struct packed {
    logic [KERNEL_SIZE-1:0] top;
    logic [KERNEL_SIZE-1:0] mid;
    logic [KERNEL_SIZE-1:0] bot;
  } window_t;

endpackage

// File: rtl/line_buffer.sv
// One-bit shift register holding one image row.
//   clk, rst_n  clock, async active-low reset
//   shift_en    advance by one position
//   din         bit shifted in
//   dout        bit shifted in DEPTH advances ago
module line_buffer #(
  parameter int unsigned DEPTH = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;

  // Row storage; reset only to keep simulation free of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (shift_en) begin
      sr_q <= {sr_q[DEPTH-2:0], din};
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/conv1_window_ctrl.sv
// Raster-stream to 3x3 window sequencer feeding the conv1 datapath.
//   clk, rst_n        clock, async active-low reset
//   pixel_in/valid_in binarised pixel stream, accepted when valid_in && ready_in
//   ready_in          low only in the single DONE cycle between frames
//   pixel_0..pixel_8  registered window, row-major, pixel_8 newest
//   valid_out_buf     one-cycle strobe per fully in-image window
//   win_idx           raster index of the window being presented
//   frame_done        one-cycle pulse alongside the last window
module conv1_window_ctrl #(
  parameter int unsigned IMG_W = conv1_pkg::IMG_W,
  parameter int unsigned IMG_H = conv1_pkg::IMG_H
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pixel_in,
  input  logic valid_in,
  output logic ready_in,
  output logic pixel_0,
  output logic pixel_1,
  output logic pixel_2,
  output logic pixel_3,
  output logic pixel_4,
  output logic pixel_5,
  output logic pixel_6,
  output logic pixel_7,
  output logic pixel_8,
  output logic valid_out_buf,
  output logic [conv1_pkg::bits_for((IMG_W-2)*(IMG_H-2))-1:0] win_idx,
  output logic frame_done
);

  import conv1_pkg::*;

  localparam int unsigned CW = bits_for(IMG_W);
  localparam int unsigned RW = bits_for(IMG_H);
  localparam int unsigned WW = bits_for((IMG_W - 2) * (IMG_H - 2));

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WW-1:0] win_idx_q, win_idx_d;
  window_t       win_q, win_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  logic accept;
  logic last_px;
  logic tap_a;
  logic tap_b;

  // Previous row (A) and the row before it (B) at the current column.
  line_buffer #(.DEPTH(IMG_W)) u_lb_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .din      (pixel_in),
    .dout     (tap_a)
  );

  line_buffer #(.DEPTH(IMG_W)) u_lb_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .din      (tap_a),
    .dout     (tap_b)
  );

  // Next-state, counter, window and output logic.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    win_idx_d = win_idx_q;
    win_d     = win_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;

    accept  = valid_in && ready_q;
    last_px = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    // Index advances after each presented window; the last one of a frame
    // is presented in DONE, so that is where it returns to zero.
    if (valid_q) begin
      win_idx_d = (state_q == DONE) ? '0 : win_idx_q + WW'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (accept && last_px) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      win_d.bot = {win_q.bot[1:0], pixel_in};
      win_d.mid = {win_q.mid[1:0], tap_a};
      win_d.top = {win_q.top[1:0], tap_b};
      // Columns 0..1 would straddle the row wrap.
      valid_d   = (row_q >= RW'(2)) && (col_q >= CW'(2));
    end

    ready_d = (state_d != DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      win_idx_q <= '0;
      win_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      win_idx_q <= win_idx_d;
      win_q     <= win_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign ready_in      = ready_q;
  assign valid_out_buf = valid_q;
  assign win_idx       = win_idx_q;
  assign frame_done    = done_q;

  assign pixel_0 = win_q.top[2];
  assign pixel_1 = win_q.top[1];
  assign pixel_2 = win_q.top[0];
  assign pixel_3 = win_q.mid[2];
  assign pixel_4 = win_q.mid[1];
  assign pixel_5 = win_q.mid[0];
  assign pixel_6 = win_q.bot[2];
  assign pixel_7 = win_q.bot[1];
  assign pixel_8 = win_q.bot[0];

endmodule

// File: tb/tb_conv1_window_ctrl.sv
// Directed bench for conv1_window_ctrl at the default 28x28 geometry.
module tb_conv1_window_ctrl;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NWIN = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pixel_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready_in;
  logic       pixel_0, pixel_1, pixel_2, pixel_3, pixel_4;
  logic       pixel_5, pixel_6, pixel_7, pixel_8;
  logic       valid_out_buf;
  logic [9:0] win_idx;
  logic       frame_done;

  conv1_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pixel_in      (pixel_in),
    .valid_in      (valid_in),
    .ready_in      (ready_in),
    .pixel_0       (pixel_0),
    .pixel_1       (pixel_1),
    .pixel_2       (pixel_2),
    .pixel_3       (pixel_3),
    .pixel_4       (pixel_4),
    .pixel_5       (pixel_5),
    .pixel_6       (pixel_6),
    .pixel_7       (pixel_7),
    .pixel_8       (pixel_8),
    .valid_out_buf (valid_out_buf),
    .win_idx       (win_idx),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Two image slots so back-to-back frames can carry different content.
  logic img [2][H][W];

  int mon_k       = 0;
  int mon_slot    = 0;
  int drv_slot    = 0;
  int pulse_cnt   = 0;
  int done_cnt    = 0;
  int rdy_low_cnt = 0;

  function automatic logic [8:0] exp_win(input int slot, input int k);
    int r0;
    int c0;
    logic [8:0] v;
    r0 = k / (W - 2);
    c0 = k % (W - 2);
    v  = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[8 - (3 * i + j)] = img[slot][r0 + i][c0 + j];
    return v;
  endfunction

  function automatic logic [8:0] got_win();
    return {pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
            pixel_5, pixel_6, pixel_7, pixel_8};
  endfunction

  // Window scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_k    = 0;
      mon_slot = drv_slot;
    end else begin
      if (!ready_in) rdy_low_cnt++;
      if (valid_out_buf) begin
        pulse_cnt++;
        if (mon_k >= NWIN) begin
          check("extra_window", 32'(mon_k), 32'(NWIN - 1));
        end else begin
          check("win_idx", 32'(win_idx), 32'(mon_k));
          check("window", 32'(got_win()), 32'(exp_win(mon_slot, mon_k)));
        end
        mon_k++;
      end
      if (frame_done) begin
        done_cnt++;
        check("done_with_valid", 32'(valid_out_buf), 32'd1);
        check("done_idx", 32'(win_idx), 32'(NWIN - 1));
        check("done_count", 32'(mon_k), 32'(NWIN));
        mon_k    = 0;
        mon_slot = 1 - mon_slot;
      end
    end
  end

  task automatic fill(input int slot, input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[slot][r][c] = 1'b1;
          1:       img[slot][r][c] = 1'((r + c) % 2);
          default: img[slot][r][c] = 1'($urandom % 2);
        endcase
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one pixel until accepted; tries = clock edges it took.
  task automatic send_pixel(input logic p, input bit chk, input int r, input int c,
                            output int tries);
    bit rdy;
    pixel_in = p;
    valid_in = 1'b1;
    tries    = 0;
    do begin
      rdy = ready_in;
      @(posedge clk);
      #1;
      tries++;
    end while (!rdy && tries < 8);
    if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
    if (chk) check("valid_after_accept", 32'(valid_out_buf), 32'(r >= 2 && c >= 2));
  endtask

  task automatic send_frame(input int slot, input bit gaps, input bit chk, input int stop_at,
                            output int first_tries);
    int t;
    drv_slot    = slot;
    first_tries = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r * W + c == stop_at) begin
          valid_in = 1'b0;
          return;
        end
        if (gaps) begin
          while ($urandom_range(1, 0) == 1) begin
            valid_in = 1'b0;
            pixel_in = 1'($urandom % 2);
            @(posedge clk);
            #1;
          end
        end
        send_pixel(img[slot][r][c], chk, r, c, t);
        if (r == 0 && c == 0) first_tries = t;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int s_p;
    int s_d;
    int s_r;
    int tries;

    // Reset values, checked while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_in), 32'd1);
    check("rst_valid", 32'(valid_out_buf), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_win_idx", 32'(win_idx), 32'd0);
    check("rst_window", 32'(got_win()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(ready_in), 32'd1);

    // All-ones frame, continuous stream.
    fill(0, 0);
    s_p = pulse_cnt; s_d = done_cnt; s_r = rdy_low_cnt;
    send_frame(0, 1'b0, 1'b0, -1, tries);
    idle(4);
    check("ones_pulses", 32'(pulse_cnt - s_p), 32'(NWIN));
    check("ones_done", 32'(done_cnt - s_d), 32'd1);
    check("ones_ready_low", 32'(rdy_low_cnt - s_r), 32'd1);

    // Checkerboard, with the validity strobe checked after every pixel.
    fill(1, 1);
    s_p = pulse_cnt; s_d = done_cnt;
    send_frame(1, 1'b0, 1'b1, -1, tries);
    idle(4);
    check("checker_pulses", 32'(pulse_cnt - s_p), 32'(NWIN));
    check("checker_done", 32'(done_cnt - s_d), 32'd1);

    // Random image with random input gaps.
    fill(0, 2);
    s_p = pulse_cnt; s_d = done_cnt;
    send_frame(0, 1'b1, 1'b0, -1, tries);
    idle(4);
    check("gaps_pulses", 32'(pulse_cnt - s_p), 32'(NWIN));
    check("gaps_done", 32'(done_cnt - s_d), 32'd1);

    // Abort after 400 pixels, then a clean frame.
    fill(1, 2);
    s_d = done_cnt;
    send_frame(1, 1'b0, 1'b0, 400, tries);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(valid_out_buf), 32'd0);
    check("abort_win_idx", 32'(win_idx), 32'd0);
    check("abort_window", 32'(got_win()), 32'd0);
    check("abort_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    check("abort_no_done", 32'(done_cnt - s_d), 32'd0);
    s_p = pulse_cnt; s_d = done_cnt;
    send_frame(1, 1'b0, 1'b0, -1, tries);
    idle(4);
    check("after_abort_pulses", 32'(pulse_cnt - s_p), 32'(NWIN));
    check("after_abort_done", 32'(done_cnt - s_d), 32'd1);

    // Back-to-back frames with valid_in held high.
    fill(0, 2);
    fill(1, 2);
    s_p = pulse_cnt; s_d = done_cnt; s_r = rdy_low_cnt;
    send_frame(0, 1'b0, 1'b0, -1, tries);
    check("b2b_f1_first_tries", 32'(tries), 32'd1);
    send_frame(1, 1'b0, 1'b0, -1, tries);
    check("b2b_f2_first_tries", 32'(tries), 32'd2);
    idle(4);
    check("b2b_pulses", 32'(pulse_cnt - s_p), 32'(2 * NWIN));
    check("b2b_done", 32'(done_cnt - s_d), 32'd2);
    check("b2b_ready_low", 32'(rdy_low_cnt - s_r), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
